occupancy_counter: RTL and testbench

//  Lot-occupancy tracker fed by the parking-lot sensor FSM's car_enter/car_exit pulses.

---
 rtl/occupancy_counter.sv | 146 ++++++++++++++
 tb/tb_occupancy_counter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_counter.sv
// Parking-lot occupancy counter: car count, free spaces, EMPTY/AVAIL/FULL status and sticky error flags.
// Define OCC_BCD_EN to build the sequential double-dabble BCD converter that drives occ_bcd/bcd_valid.
module occupancy_counter #(
   parameter int CAPACITY   = 99,
   parameter int CNT_W      = 7,
   parameter int BCD_DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    car_enter,
   input  logic                    car_exit,
   input  logic                    clr_err,
   output logic [CNT_W-1:0]        count,
   output logic [CNT_W-1:0]        spaces_left,
   output logic                    lot_empty,
   output logic                    lot_full,
   output logic                    err_overflow,
   output logic                    err_underflow,
   output logic [4*BCD_DIGITS-1:0] occ_bcd,
   output logic                    bcd_valid
);

   localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

   // One-hot encoding so lot_empty/lot_full are straight register bits
   typedef enum logic [2:0] {
      S_EMPTY = 3'b001,
      S_AVAIL = 3'b010,
      S_FULL  = 3'b100
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_count, r_spaces, w_count_nxt;
   logic             r_err_ov, r_err_un;
   logic             w_inc, w_dec, w_ovf, w_unf, w_chg;

   assign w_inc = car_enter & ~car_exit & (r_count != CAP_V);
   assign w_dec = car_exit & ~car_enter & (r_count != '0);
   assign w_ovf = car_enter & ~car_exit & (r_count == CAP_V);
   assign w_unf = car_exit & ~car_enter & (r_count == '0);
   assign w_chg = w_inc | w_dec;

   always_comb begin
      w_count_nxt = r_count;
      if (w_inc)
         w_count_nxt = r_count + CNT_W'(1);
      else if (w_dec)
         w_count_nxt = r_count - CNT_W'(1);
   end

   // Next status follows the next count, which also covers CAPACITY==1 (EMPTY<->FULL)
   always_comb begin
      w_state_nxt = r_state;
      if (w_chg) begin
         if (w_count_nxt == '0)
            w_state_nxt = S_EMPTY;
         else if (w_count_nxt == CAP_V)
            w_state_nxt = S_FULL;
         else
            w_state_nxt = S_AVAIL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_EMPTY;
         r_count  <= '0;
         r_spaces <= CAP_V;
         r_err_ov <= 1'b0;
         r_err_un <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_spaces <= CAP_V - w_count_nxt;
         if (w_ovf)
            r_err_ov <= 1'b1;
         else if (clr_err)
            r_err_ov <= 1'b0;
         if (w_unf)
            r_err_un <= 1'b1;
         else if (clr_err)
            r_err_un <= 1'b0;
      end
   end

   assign count         = r_count;
   assign spaces_left   = r_spaces;
   assign lot_empty     = r_state[0];
   assign lot_full      = r_state[2];
   assign err_overflow  = r_err_ov;
   assign err_underflow = r_err_un;

`ifdef OCC_BCD_EN
   localparam int                BW   = 4*BCD_DIGITS;
   localparam int                STW  = $clog2(CNT_W+1);
   localparam logic [STW-1:0]    LAST = STW'(CNT_W-1);

   logic [CNT_W-1:0] r_bin;
   logic [BW-1:0]    r_acc, r_bcd, w_adj, w_shift;
   logic [STW-1:0]   r_step;
   logic             r_busy, r_valid;

   always_comb begin
      w_adj = r_acc;
      for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
         if (r_acc[4*d +: 4] >= 4'd5)
            w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
      w_shift = {w_adj[BW-2:0], r_bin[CNT_W-1]};
   end

   // A count change always reloads, so an in-flight stale result is simply dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin   <= '0;
         r_acc   <= '0;
         r_step  <= '0;
         r_busy  <= 1'b0;
         r_bcd   <= '0;
         r_valid <= 1'b1;
      end else if (w_chg) begin
         r_bin   <= w_count_nxt;
         r_acc   <= '0;
         r_step  <= '0;
         r_busy  <= 1'b1;
         r_valid <= 1'b0;
      end else if (r_busy) begin
         r_bin  <= r_bin << 1;
         r_acc  <= w_shift;
         r_step <= r_step + STW'(1);
         if (r_step == LAST) begin
            r_busy  <= 1'b0;
            r_bcd   <= w_shift;
            r_valid <= 1'b1;
         end
      end
   end

   assign occ_bcd   = r_bcd;
   assign bcd_valid = r_valid;
`else
   assign occ_bcd   = '0;
   assign bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_occupancy_counter.sv
// Scoreboard bench for occupancy_counter: count/status/error expectations and BCD publishes
// are pushed when stimulus is driven and popped when the DUT output is sampled.
module tb_occupancy_counter;

   localparam int CAP = 99;
   localparam int W   = 7;
   localparam int DIG = 3;

   logic            clk = 1'b0;
   logic            reset, car_enter, car_exit, clr_err;
   logic [W-1:0]    count, spaces_left;
   logic            lot_empty, lot_full, err_overflow, err_underflow;
   logic [4*DIG-1:0] occ_bcd;
   logic            bcd_valid;

   typedef struct packed {
      logic [W-1:0] cnt;
      logic [W-1:0] sp;
      logic         emp;
      logic         ful;
      logic         eov;
      logic         eun;
   } st_t;

   st_t          sb[$];
   logic [11:0]  bcd_q[$];
   int unsigned  m_cnt;
   logic         m_eov, m_eun;
   int           nchk = 0;
   int           nerr = 0;

`ifdef OCC_BCD_EN
   localparam logic RST_VALID = 1'b1;
`else
   localparam logic RST_VALID = 1'b0;
`endif

   occupancy_counter #(.CAPACITY(CAP), .CNT_W(W), .BCD_DIGITS(DIG)) dut (
      .clk(clk), .reset(reset), .car_enter(car_enter), .car_exit(car_exit), .clr_err(clr_err),
      .count(count), .spaces_left(spaces_left), .lot_empty(lot_empty), .lot_full(lot_full),
      .err_overflow(err_overflow), .err_underflow(err_underflow),
      .occ_bcd(occ_bcd), .bcd_valid(bcd_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic st_t obs();
      st_t r;
      r = {count, spaces_left, lot_empty, lot_full, err_overflow, err_underflow};
      return r;
   endfunction

   function automatic logic [11:0] to_bcd(input int unsigned v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic st_t model_state();
      st_t e;
      e.cnt = W'(m_cnt);
      e.sp  = W'(CAP - m_cnt);
      e.emp = (m_cnt == 0);
      e.ful = (m_cnt == CAP);
      e.eov = m_eov;
      e.eun = m_eun;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_eov = 1'b0;
      m_eun = 1'b0;
      sb.delete();
      bcd_q.delete();
   endtask

   task automatic drive(input logic en, input logic ex, input logic clr);
      car_enter = en;
      car_exit  = ex;
      clr_err   = clr;
      if (clr) begin
         m_eov = 1'b0;
         m_eun = 1'b0;
      end
      if (en && !ex) begin
         if (m_cnt == CAP) m_eov = 1'b1;
         else begin m_cnt++; bcd_q.push_back(to_bcd(m_cnt)); end
      end else if (ex && !en) begin
         if (m_cnt == 0) m_eun = 1'b1;
         else begin m_cnt--; bcd_q.push_back(to_bcd(m_cnt)); end
      end
      sb.push_back(model_state());
      tick();
      car_enter = 1'b0;
      car_exit  = 1'b0;
      clr_err   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      car_enter = 1'b0; car_exit = 1'b0; clr_err = 1'b0;
      model_reset();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic fill_to(input int unsigned n);
      while (m_cnt < n) drive(1'b1, 1'b0, 1'b0);
      sb.delete();
   endtask

   task automatic test_reset();
      st_t e;
      reset = 1'b1;
      car_enter = 1'b0; car_exit = 1'b0; clr_err = 1'b0;
      model_reset();
      sb.push_back(model_state());
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs() !== e) begin
         nerr++; $display("FAIL reset_state: got %h expected %h", obs(), e);
      end
      nchk++;
      if ({occ_bcd, bcd_valid} !== {12'h000, RST_VALID}) begin
         nerr++; $display("FAIL reset_bcd: got %h/%b expected 000/%b", occ_bcd, bcd_valid, RST_VALID);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_enter();
      st_t e;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         nchk++;
         if (obs() !== e) begin
            nerr++; $display("FAIL enter_%0d: got %h expected %h", i, obs(), e);
         end
         drive(1'b0, 1'b0, 1'b0);
         e = sb.pop_front();
         nchk++;
         if (obs() !== e) begin
            nerr++; $display("FAIL enter_idle_%0d: got %h expected %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_fill_overflow();
      st_t e;
      while (m_cnt < CAP) begin
         drive(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         nchk++;
         if (obs() !== e) begin
            nerr++; $display("FAIL fill_%0d: got %h expected %h", m_cnt, obs(), e);
         end
      end
      // extra enter, clear, clear racing a new overflow, final clear
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1'b1, 1'b0, 1'b0);
            1: drive(1'b0, 1'b0, 1'b1);
            2: drive(1'b1, 1'b0, 1'b1);
            default: drive(1'b0, 1'b0, 1'b1);
         endcase
         e = sb.pop_front();
         nchk++;
         if (obs() !== e) begin
            nerr++; $display("FAIL overflow_step%0d: got %h expected %h", i, obs(), e);
         end
      end
   endtask

   task automatic test_full_simul();
      st_t e;
      drive(1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      nchk++;
      if (obs() !== e) begin
         nerr++; $display("FAIL full_enter_exit: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_drain_underflow();
      st_t e;
      while (m_cnt > 0) begin
         drive(1'b0, 1'b1, 1'b0);
         e = sb.pop_front();
         nchk++;
         if (obs() !== e) begin
            nerr++; $display("FAIL drain_%0d: got %h expected %h", m_cnt, obs(), e);
         end
      end
      // exit at empty, clear racing 2nd exit, both pulses at empty, clear
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1'b0, 1'b1, 1'b0);
            1: drive(1'b0, 1'b1, 1'b1);
            2: drive(1'b1, 1'b1, 1'b0);
            default: drive(1'b0, 1'b0, 1'b1);
         endcase
         e = sb.pop_front();
         nchk++;
         if (obs() !== e) begin
            nerr++; $display("FAIL underflow_step%0d: got %h expected %h", i, obs(), e);
         end
      end
   endtask

`ifdef OCC_BCD_EN
   task automatic test_bcd();
      logic [11:0] held, exp;
      int          low, n;
      do_reset();
      fill_to(41);
      n = 0;
      while (!bcd_valid && n < 20) begin tick(); n++; end
      exp = bcd_q[$];
      bcd_q.delete();
      nchk++;
      if (!bcd_valid || occ_bcd !== exp) begin
         nerr++; $display("FAIL bcd_41: got %h/%b expected %h/1", occ_bcd, bcd_valid, exp);
      end
      held = exp;

      for (int pass = 0; pass < 2; pass++) begin
         drive(1'b1, 1'b0, 1'b0);
         sb.delete();
         if (pass == 1) begin
            for (int k = 0; k < 2; k++) begin
               nchk++;
               if (bcd_valid !== 1'b0 || occ_bcd !== held) begin
                  nerr++; $display("FAIL bcd_hold_pre: got %h/%b expected %h/0", occ_bcd, bcd_valid, held);
               end
               tick();
            end
            drive(1'b1, 1'b0, 1'b0);
            sb.delete();
         end
         low = 0;
         while (!bcd_valid && low < 20) begin
            nchk++;
            if (occ_bcd !== held) begin
               nerr++; $display("FAIL bcd_hold: got %h expected %h", occ_bcd, held);
            end
            low++;
            tick();
         end
         exp = bcd_q[$];
         bcd_q.delete();
         nchk++;
         if (!bcd_valid || occ_bcd !== exp) begin
            nerr++; $display("FAIL bcd_publish_%0d: got %h/%b expected %h/1", pass, occ_bcd, bcd_valid, exp);
         end
         nchk++;
         if (low != W) begin
            nerr++; $display("FAIL bcd_latency_%0d: got %0d expected %0d", pass, low, W);
         end
         held = exp;
      end
   endtask
`else
   task automatic test_bcd();
      do_reset();
      drive(1'b1, 1'b0, 1'b0);
      sb.delete();
      for (int k = 0; k < W + 2; k++) begin
         nchk++;
         if ({occ_bcd, bcd_valid} !== 13'd0) begin
            nerr++; $display("FAIL bcd_tied: got %h/%b expected 000/0", occ_bcd, bcd_valid);
         end
         tick();
      end
   endtask
`endif

   task automatic test_reset_mid();
      st_t e;
      do_reset();
      fill_to(57);
      nchk++;
      if (count !== W'(57)) begin
         nerr++; $display("FAIL pre_reset_count: got %0d expected 57", count);
      end
      tick();
      tick();
      reset = 1'b1;
      model_reset();
      sb.push_back(model_state());
      #2;
      e = sb.pop_front();
      nchk++;
      if (obs() !== e) begin
         nerr++; $display("FAIL mid_reset_state: got %h expected %h", obs(), e);
      end
      nchk++;
      if ({occ_bcd, bcd_valid} !== {12'h000, RST_VALID}) begin
         nerr++; $display("FAIL mid_reset_bcd: got %h/%b expected 000/%b", occ_bcd, bcd_valid, RST_VALID);
      end
      tick();
      reset = 1'b0;
      for (int k = 0; k < W + 2; k++) tick();
      nchk++;
      if ({occ_bcd, bcd_valid} !== {12'h000, RST_VALID}) begin
         nerr++; $display("FAIL post_reset_bcd: got %h/%b expected 000/%b", occ_bcd, bcd_valid, RST_VALID);
      end
      e = model_state();
      nchk++;
      if (obs() !== e) begin
         nerr++; $display("FAIL post_reset_state: got %h expected %h", obs(), e);
      end
   endtask

   initial begin
      reset = 1'b1;
      car_enter = 1'b0; car_exit = 1'b0; clr_err = 1'b0;
      model_reset();
      test_reset();
      test_enter();
      test_fill_overflow();
      test_full_simul();
      test_drain_underflow();
      test_bcd();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
